// File: rtl/axi4_slv_pkg.sv
// Shared types and constants for the AXI4 slave RAM responder.
// Enables DECERR/SLVERR responses when AXI4_SLV_RESP_ERR_EN is defined.
package axi4_slv_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } rd_state_t;

  // True when a burst starting at word start runs past the last RAM word.
  function automatic logic over_range(
    input logic [31:0] start,
    input logic [7:0]  len,
    input logic [31:0] depth
  );
    return (start + {24'd0, len}) >= depth;
  endfunction

endpackage

// File: rtl/axi4_slv_dpram.sv
// Simple dual-port RAM: byte-enable write port, registered read port.
// A read and write to the same word in one cycle returns the old word.
module axi4_slv_dpram
  import axi4_slv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [AW-1:0]           waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    re_i,
  input  logic [AW-1:0]           raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int unsigned SW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Registered read and byte-masked write; NBA ordering gives read-first.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
    if (we_i) begin
      for (int b = 0; b < SW; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4_slave_ram_resp.sv
// AXI4 slave backed by a dual-port RAM; INCR-only, one burst per channel.
// Optional error responses are enabled by AXI4_SLV_RESP_ERR_EN.
module axi4_slave_ram_resp
  import axi4_slv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 2048
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ID_WIDTH-1:0]     s_arid,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready
);

  localparam int unsigned OFFS = $clog2(DATA_WIDTH / 8);
  localparam int unsigned AW   = $clog2(MEM_DEPTH);

`ifdef AXI4_SLV_RESP_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  // Size, burst type and out-of-word address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_awsize, s_awburst, s_arsize, s_arburst,
                       s_awaddr[OFFS-1:0], s_araddr[OFFS-1:0],
                       s_awaddr[ADDR_WIDTH-1:OFFS+AW],
                       s_araddr[ADDR_WIDTH-1:OFFS+AW]};

  logic init_q;

  wr_state_t           wst_q, wst_d;
  logic [ID_WIDTH-1:0] awid_q, awid_d;
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [7:0]          wlen_q, wlen_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                wdec_q, wdec_d;
  logic                ram_we;
  logic                err_wlast;
  logic                wdone;

  rd_state_t           rdst_q, rdst_d;
  logic [ID_WIDTH-1:0] arid_q, arid_d;
  logic [AW-1:0]       rptr_q, rptr_d;
  logic [7:0]          rlen_q, rlen_d;
  logic [8:0]          icnt_q, icnt_d;
  logic                rdec_q, rdec_d;
  logic                issue, pop, room;

  logic                  infl_q, infl_last_q;
  logic [DATA_WIDTH-1:0] bdata_q [2];
  logic [1:0]            blast_q;
  logic                  bwp_q, brp_q;
  logic [1:0]            bcnt_q;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Holds both ready outputs low until the first cycle out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) init_q <= 1'b0;
    else     init_q <= 1'b1;
  end

  // Write channel state and burst context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wst_q   <= W_IDLE;
      awid_q  <= '0;
      wptr_q  <= '0;
      wlen_q  <= '0;
      wcnt_q  <= '0;
      bresp_q <= RESP_OKAY;
      wdec_q  <= 1'b0;
    end else begin
      wst_q   <= wst_d;
      awid_q  <= awid_d;
      wptr_q  <= wptr_d;
      wlen_q  <= wlen_d;
      wcnt_q  <= wcnt_d;
      bresp_q <= bresp_d;
      wdec_q  <= wdec_d;
    end
  end

  // Write FSM: accept AW, take one W beat per cycle, then present B.
  always_comb begin
    wst_d     = wst_q;
    awid_d    = awid_q;
    wptr_d    = wptr_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    bresp_d   = bresp_q;
    wdec_d    = wdec_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    ram_we    = 1'b0;
    wdone     = s_wlast || (wcnt_q == wlen_q);
    err_wlast = ErrEn && (s_wlast != (wcnt_q == wlen_q));
    unique case (wst_q)
      W_IDLE: begin
        s_awready = init_q;
        if (init_q && s_awvalid) begin
          awid_d = s_awid;
          wptr_d = s_awaddr[OFFS +: AW];
          wlen_d = s_awlen;
          wcnt_d = '0;
          wdec_d = ErrEn && over_range(32'(s_awaddr[OFFS +: AW]),
                                       s_awlen, 32'(MEM_DEPTH));
          wst_d  = W_DATA;
        end
      end
      W_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          ram_we = !wdec_q;
          wptr_d = wptr_q + 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (wdone) begin
            wst_d = W_RESP;
            if (wdec_q)         bresp_d = RESP_DECERR;
            else if (err_wlast) bresp_d = RESP_SLVERR;
            else                bresp_d = RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) begin
          wst_d   = W_IDLE;
          bresp_d = RESP_OKAY;
        end
      end
      default: wst_d = W_IDLE;
    endcase
  end

  assign s_bid   = awid_q;
  assign s_bresp = bresp_q;

  // Read channel state and burst context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdst_q <= R_IDLE;
      arid_q <= '0;
      rptr_q <= '0;
      rlen_q <= '0;
      icnt_q <= '0;
      rdec_q <= 1'b0;
    end else begin
      rdst_q <= rdst_d;
      arid_q <= arid_d;
      rptr_q <= rptr_d;
      rlen_q <= rlen_d;
      icnt_q <= icnt_d;
      rdec_q <= rdec_d;
    end
  end

  // Read FSM: issue RAM reads while the skid buffer has room.
  always_comb begin
    rdst_d    = rdst_q;
    arid_d    = arid_q;
    rptr_d    = rptr_q;
    rlen_d    = rlen_q;
    icnt_d    = icnt_q;
    rdec_d    = rdec_q;
    s_arready = 1'b0;
    issue     = 1'b0;
    pop       = (bcnt_q != 2'd0) && s_rready;
    room      = ({1'b0, bcnt_q} + {2'b0, infl_q}
                 - {2'b0, pop}) < 3'd2;
    unique case (rdst_q)
      R_IDLE: begin
        s_arready = init_q;
        if (init_q && s_arvalid) begin
          arid_d = s_arid;
          rptr_d = s_araddr[OFFS +: AW];
          rlen_d = s_arlen;
          icnt_d = '0;
          rdec_d = ErrEn && over_range(32'(s_araddr[OFFS +: AW]),
                                       s_arlen, 32'(MEM_DEPTH));
          rdst_d = R_BURST;
        end
      end
      R_BURST: begin
        issue = room && (icnt_q <= {1'b0, rlen_q});
        if (issue) begin
          rptr_d = rptr_q + 1'b1;
          icnt_d = icnt_q + 1'b1;
        end
        if (pop && blast_q[brp_q]) rdst_d = R_IDLE;
      end
      default: rdst_d = R_IDLE;
    endcase
  end

  // Two-entry skid buffer fed by the one-cycle RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      bdata_q[0]  <= '0;
      bdata_q[1]  <= '0;
      blast_q     <= '0;
      bwp_q       <= 1'b0;
      brp_q       <= 1'b0;
      bcnt_q      <= '0;
    end else begin
      infl_q      <= issue;
      infl_last_q <= issue && (icnt_q == {1'b0, rlen_q});
      if (infl_q) begin
        bdata_q[bwp_q] <= rdec_q ? '0 : ram_rdata;
        blast_q[bwp_q] <= infl_last_q;
      end
      bwp_q  <= bwp_q ^ infl_q;
      brp_q  <= brp_q ^ pop;
      bcnt_q <= bcnt_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

  assign s_rvalid = (bcnt_q != 2'd0);
  assign s_rdata  = s_rvalid ? bdata_q[brp_q] : '0;
  assign s_rlast  = s_rvalid & blast_q[brp_q];
  assign s_rresp  = (s_rvalid && rdec_q) ? RESP_DECERR : RESP_OKAY;
  assign s_rid    = arid_q;

  axi4_slv_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wptr_q),
    .wdata_i (s_wdata),
    .wstrb_i (s_wstrb),
    .re_i    (issue),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_axi4_slave_ram_resp.sv
// Directed bench for axi4_slave_ram_resp; table of write/read bursts
// plus hand sequences. Honours AXI4_SLV_RESP_ERR_EN when defined.
module tb_axi4_slave_ram_resp;

  localparam int DW    = 128;
  localparam int ADW   = 32;
  localparam int IW    = 4;
  localparam int DEPTH = 2048;

  logic clk, rst;
  logic [IW-1:0]   s_awid, s_arid, s_bid, s_rid;
  logic [ADW-1:0]  s_awaddr, s_araddr;
  logic [7:0]      s_awlen, s_arlen;
  logic [2:0]      s_awsize, s_arsize;
  logic [1:0]      s_awburst, s_arburst, s_bresp, s_rresp;
  logic            s_awvalid, s_awready, s_arvalid, s_arready;
  logic [DW-1:0]   s_wdata, s_rdata;
  logic [DW/8-1:0] s_wstrb;
  logic            s_wlast, s_wvalid, s_wready;
  logic            s_bvalid, s_bready;
  logic            s_rlast, s_rvalid, s_rready;

  axi4_slave_ram_resp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (ADW),
    .ID_WIDTH   (IW),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .clk (clk), .rst (rst),
    .s_awid (s_awid), .s_awaddr (s_awaddr), .s_awlen (s_awlen),
    .s_awsize (s_awsize), .s_awburst (s_awburst),
    .s_awvalid (s_awvalid), .s_awready (s_awready),
    .s_wdata (s_wdata), .s_wstrb (s_wstrb), .s_wlast (s_wlast),
    .s_wvalid (s_wvalid), .s_wready (s_wready),
    .s_bid (s_bid), .s_bresp (s_bresp), .s_bvalid (s_bvalid),
    .s_bready (s_bready),
    .s_arid (s_arid), .s_araddr (s_araddr), .s_arlen (s_arlen),
    .s_arsize (s_arsize), .s_arburst (s_arburst),
    .s_arvalid (s_arvalid), .s_arready (s_arready),
    .s_rid (s_rid), .s_rdata (s_rdata), .s_rresp (s_rresp),
    .s_rlast (s_rlast), .s_rvalid (s_rvalid), .s_rready (s_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] seed;
    int          rmode;
  } vec_t;

  vec_t          tbl [5];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] model [int];
  logic [DW-1:0] last_rdata;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fill: 0 = seeded pattern, 1 = all ones, 2 = all zeros.
  function automatic logic [DW-1:0] beat_data(input logic [31:0] seed,
                                                input int b, input int fill);
    if (fill == 1) return '1;
    if (fill == 2) return '0;
    return {seed, 32'(b), ~seed, seed ^ (32'(b) * 32'h0101_0101)};
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 4) % DEPTH);
  endfunction

  function automatic logic is_dec(input logic [31:0] addr,
                                  input logic [7:0] len);
`ifdef AXI4_SLV_RESP_ERR_EN
    return (word_of(addr) + int'(len)) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_wr(input int w, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] strb);
    if (!model.exists(w)) model[w] = '0;
    for (int i = 0; i < DW/8; i++)
      if (strb[i]) model[w][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [31:0] seed,
                          input logic [15:0] strb, input int last_at,
                          input int fill);
    int t;
    logic dec;
    logic [1:0] er;
    logic [DW-1:0] d;
    dec = is_dec(addr, len);
    er  = 2'b00;
`ifdef AXI4_SLV_RESP_ERR_EN
    if (dec) er = 2'b11;
    else if (last_at != int'(len)) er = 2'b10;
`endif
    s_awid = id; s_awaddr = addr; s_awlen = len;
    s_awsize = 3'd4; s_awburst = 2'b01; s_awvalid = 1'b1;
    t = 0;
    while (!s_awready && t < 50) begin tick(); t++; end
    chk("aw_ready", s_awready, 1);
    tick();
    s_awvalid = 1'b0;
    for (int b = 0; b <= last_at; b++) begin
      d = beat_data(seed, b, fill);
      s_wvalid = 1'b1; s_wdata = d; s_wstrb = strb;
      s_wlast = (b == last_at);
      chk("w_ready", s_wready, 1);
      tick();
      if (!dec) model_wr((word_of(addr) + b) % DEPTH, d, strb);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    chk("b_valid", s_bvalid, 1);
    chk("b_id", s_bid, id);
    chk("b_resp", s_bresp, er);
    tick();
    chk("b_hold", s_bvalid, 1);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk("b_done", s_bvalid, 0);
    chk("aw_idle", s_awready, 1);
  endtask

  // mode 0: rready held high; mode 1: rready toggles 1,0,0,1.
  task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input int mode);
    int t, k, beat, first_k, last_k, w;
    logic dec, rr, held_v;
    logic [1:0] er;
    logic [3:0] pat;
    logic [DW-1:0] held, ed;
    dec = is_dec(addr, len);
    er  = dec ? 2'b11 : 2'b00;
    pat = 4'b1001;
    s_arid = id; s_araddr = addr; s_arlen = len;
    s_arsize = 3'd4; s_arburst = 2'b01; s_arvalid = 1'b1;
    t = 0;
    while (!s_arready && t < 50) begin tick(); t++; end
    chk("ar_ready", s_arready, 1);
    tick();
    s_arvalid = 1'b0;
    k = 0; beat = 0; first_k = -1; last_k = 0; held_v = 1'b0;
    held = '0;
    while (beat <= int'(len) && k < 400) begin
      rr = (mode == 0) ? 1'b1 : pat[k % 4];
      s_rready = rr;
      if (held_v) begin
        chk("r_stall_valid", s_rvalid, 1);
        chk("r_stall_data", s_rdata, held);
        held_v = 1'b0;
      end
      if (s_rvalid) begin
        if (first_k < 0) first_k = k;
        if (rr) begin
          w = (word_of(addr) + beat) % DEPTH;
          if (dec) ed = '0;
          else     ed = model[w];
          chk("r_data", s_rdata, ed);
          chk("r_last", s_rlast, beat == int'(len));
          chk("r_resp", s_rresp, er);
          chk("r_id", s_rid, id);
          last_rdata = s_rdata;
          beat++;
          last_k = k;
        end else begin
          held_v = 1'b1;
          held = s_rdata;
        end
      end
      tick();
      k++;
    end
    s_rready = 1'b0;
    chk("r_beats", beat, int'(len) + 1);
    if (mode == 0) begin
      chk("r_first_lat", first_k, 2);
      chk("r_rate", last_k - first_k, int'(len));
    end
    chk("r_end_valid", s_rvalid, 0);
    chk("ar_idle", s_arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] old_w, new_w;
    tbl[0] = '{4'd3,  32'd16384, 8'd7,  32'hA5A5_0001, 0};
    tbl[1] = '{4'd9,  32'h4107,  8'd0,  32'h1234_5678, 0};
    tbl[2] = '{4'd1,  32'd0,     8'd15, 32'hC0DE_0002, 1};
    tbl[3] = '{4'd15, 32'd32752, 8'd0,  32'h7777_0003, 1};
    tbl[4] = '{4'd7,  (DEPTH - 4) * 16, 8'd7, 32'h5A5A_0004, 0};

    rst = 1'b1;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
    s_awburst = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
    s_arburst = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    last_rdata = '0;
    repeat (3) tick();

    chk("rst_awready", s_awready, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_wready", s_wready, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rdata", s_rdata, 0);

    rst = 1'b0;
    tick();
    chk("rel_awready", s_awready, 1);
    chk("rel_arready", s_arready, 1);
    chk("rel_bvalid", s_bvalid, 0);
    chk("rel_rvalid", s_rvalid, 0);

    for (int i = 0; i < 5; i++) begin
      wr_burst(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].seed,
               16'hFFFF, int'(tbl[i].len), 0);
      rd_burst(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].rmode);
    end

    rd_burst(4'd4, 32'd16384, 8'd7, 1);

    wr_burst(4'd2, 32'd0, 8'd0, 32'd0, 16'hFFFF, 0, 1);
    wr_burst(4'd2, 32'd0, 8'd0, 32'd0, 16'h000F, 0, 2);
    rd_burst(4'd2, 32'd0, 8'd0, 0);
    chk("strobe_word", last_rdata,
        128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000);

    wr_burst(4'd6, 32'h5000, 8'd3, 32'hBEEF_0005, 16'hFFFF, 1, 0);
    rd_burst(4'd6, 32'h5000, 8'd1, 0);

    old_w = model[1040];
    new_w = beat_data(32'hCAFE_0006, 0, 0);
    s_awid = 4'd8; s_awaddr = 32'h4100; s_awlen = 8'd0;
    s_awvalid = 1'b1;
    s_arid = 4'd8; s_araddr = 32'h4100; s_arlen = 8'd0;
    s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_arvalid = 1'b0;
    s_wvalid = 1'b1; s_wdata = new_w; s_wstrb = 16'hFFFF;
    s_wlast = 1'b1; s_rready = 1'b1;
    tick();
    s_wvalid = 1'b0; s_wlast = 1'b0;
    chk("col_bvalid", s_bvalid, 1);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk("col_rvalid", s_rvalid, 1);
    chk("col_old_data", s_rdata, old_w);
    tick();
    s_rready = 1'b0;
    chk("col_rdone", s_rvalid, 0);
    model[1040] = new_w;
    rd_burst(4'd8, 32'h4100, 8'd0, 0);

    s_awid = 4'd11; s_awaddr = 32'h6000; s_awlen = 8'd3;
    s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_wvalid = 1'b1; s_wstrb = 16'hFFFF; s_wlast = 1'b0;
      s_wdata = beat_data(32'hD00D_0007, b, 0);
      tick();
      model_wr(1536 + b, s_wdata, 16'hFFFF);
    end
    s_wvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_awready", s_awready, 0);
    chk("mid_rst_wready", s_wready, 0);
    chk("mid_rst_bvalid", s_bvalid, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_awready", s_awready, 1);
    chk("post_rst_wready", s_wready, 0);
    rd_burst(4'd11, 32'h6000, 8'd1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
